// File: rtl/bank_isu_credit_ctrl_if.sv
// Handshake bundle between the bank issue queue and its read-credit manager.
// The IQ side uses the master modport; the credit manager uses the slave modport.
interface bank_isu_credit_ctrl_if #(
   parameter int CHANNEL_NUM = 4,
   parameter int CH_ID_W     = 2,
   parameter int PTR_WIDTH   = 4,
   parameter int DEPTH       = 16,
   parameter int CREDIT_W    = 4
);
   logic                                  enq_valid;
   logic [PTR_WIDTH-1:0]                  enq_ptr;
   logic                                  enq_is_read;
   logic [CH_ID_W-1:0]                    enq_ch_id;
   logic                                  deq_valid;
   logic [PTR_WIDTH-1:0]                  deq_ptr;
   logic                                  flush;
   logic [PTR_WIDTH-1:0]                  bottom_ptr;
   logic [CHANNEL_NUM-1:0]                credit_release;
   logic [DEPTH-1:0]                      credit_allow;
   logic [CHANNEL_NUM*CREDIT_W-1:0]       credit_num;
   logic [CHANNEL_NUM*(PTR_WIDTH+1)-1:0]  pending_num;
   logic                                  err;

   modport master (
      output enq_valid, enq_ptr, enq_is_read, enq_ch_id,
      output deq_valid, deq_ptr, flush, bottom_ptr, credit_release,
      input  credit_allow, credit_num, pending_num, err
   );

   modport slave (
      input  enq_valid, enq_ptr, enq_is_read, enq_ch_id,
      input  deq_valid, deq_ptr, flush, bottom_ptr, credit_release,
      output credit_allow, credit_num, pending_num, err
   );
endinterface

// File: rtl/bank_isu_credit_ctrl.sv
// Per-channel read-credit manager for the bank issue queue.
// Tracks free credits and credit-waiting reads per channel, grants the oldest
// waiting read (age measured from bottom_ptr) one credit per channel per cycle,
// and drives a registered per-entry issue-allow vector.
module bank_isu_credit_ctrl #(
   parameter int CHANNEL_NUM = 4,
   parameter int CH_ID_W     = 2,
   parameter int PTR_WIDTH   = 4,
   parameter int DEPTH       = 16,
   parameter int CREDIT_MAX  = 8,
   parameter int CREDIT_W    = 4
) (
   input logic                    clk,
   input logic                    rst,
   bank_isu_credit_ctrl_if.slave  bus
);
   localparam int PEND_W = PTR_WIDTH + 1;

   logic [DEPTH-1:0]     r_valid;
   logic [DEPTH-1:0]     r_is_read;
   logic [DEPTH-1:0]     r_allow;
   logic [CH_ID_W-1:0]   r_ch [DEPTH];
   logic [CREDIT_W-1:0]  r_credit [CHANNEL_NUM];
   logic [PEND_W-1:0]    r_pending [CHANNEL_NUM];
   logic                 r_err;

   logic [DEPTH-1:0]     w_valid_nxt;
   logic [DEPTH-1:0]     w_is_read_nxt;
   logic [DEPTH-1:0]     w_allow_nxt;
   logic [CH_ID_W-1:0]   w_ch_nxt [DEPTH];
   logic [CREDIT_W-1:0]  w_credit_nxt [CHANNEL_NUM];
   logic [PEND_W-1:0]    w_pending_nxt [CHANNEL_NUM];
   logic                 w_err_nxt;
   logic [CHANNEL_NUM-1:0] w_grant;
   logic [PTR_WIDTH-1:0] w_grant_slot [CHANNEL_NUM];

   // Per channel: find the oldest waiting read, scanning upward from bottom_ptr with wrap
   always_comb begin
      logic [PTR_WIDTH-1:0] idx;
      logic                 found;
      idx = '0;
      for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
         found           = 1'b0;
         w_grant_slot[c] = '0;
         if (r_pending[c] != '0 && r_credit[c] != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               idx = bus.bottom_ptr + PTR_WIDTH'(i);
               if (!found && r_valid[idx] && r_is_read[idx] && !r_allow[idx] &&
                   r_ch[idx] == CH_ID_W'(c)) begin
                  found           = 1'b1;
                  w_grant_slot[c] = idx;
               end
            end
         end
         w_grant[c] = found;
      end
   end

   // Next-state for entries, credits, pending counts and the sticky error flag
   always_comb begin
      logic [CHANNEL_NUM-1:0] enq_alloc;
      logic [CHANNEL_NUM-1:0] enq_pend;
      logic [CHANNEL_NUM-1:0] deq_pend;
      logic [CHANNEL_NUM-1:0] grant;
      int                     p;
      w_valid_nxt   = r_valid;
      w_is_read_nxt = r_is_read;
      w_allow_nxt   = r_allow;
      w_ch_nxt      = r_ch;
      w_credit_nxt  = r_credit;
      w_pending_nxt = r_pending;
      w_err_nxt     = r_err;
      enq_alloc     = '0;
      enq_pend      = '0;
      deq_pend      = '0;
      p             = 0;
      grant         = bus.flush ? '0 : w_grant;

      // A channel granting this cycle sends a new read to the back of its queue
      if (!bus.flush && bus.enq_valid && bus.enq_is_read) begin
         if (r_pending[bus.enq_ch_id] == '0 && r_credit[bus.enq_ch_id] != '0 &&
             !grant[bus.enq_ch_id])
            enq_alloc[bus.enq_ch_id] = 1'b1;
         else
            enq_pend[bus.enq_ch_id] = 1'b1;
      end

      if (bus.flush) begin
         w_valid_nxt = '0;
         w_allow_nxt = '0;
         for (int unsigned c = 0; c < CHANNEL_NUM; c++)
            w_pending_nxt[c] = '0;
      end else begin
         for (int unsigned c = 0; c < CHANNEL_NUM; c++)
            if (grant[c])
               w_allow_nxt[w_grant_slot[c]] = 1'b1;

         // Dequeue is applied before enqueue so a slot can be retired and refilled together
         if (bus.deq_valid) begin
            if (r_valid[bus.deq_ptr]) begin
               w_valid_nxt[bus.deq_ptr] = 1'b0;
               w_allow_nxt[bus.deq_ptr] = 1'b0;
               if (r_is_read[bus.deq_ptr] && !r_allow[bus.deq_ptr]) begin
                  w_err_nxt                 = 1'b1;
                  deq_pend[r_ch[bus.deq_ptr]] = 1'b1;
               end
            end else begin
               w_err_nxt = 1'b1;
            end
         end

         if (bus.enq_valid) begin
            if (r_valid[bus.enq_ptr] && !(bus.deq_valid && bus.deq_ptr == bus.enq_ptr))
               w_err_nxt = 1'b1;
            w_valid_nxt[bus.enq_ptr]   = 1'b1;
            w_is_read_nxt[bus.enq_ptr] = bus.enq_is_read;
            w_ch_nxt[bus.enq_ptr]      = bus.enq_ch_id;
            w_allow_nxt[bus.enq_ptr]   = !bus.enq_is_read || (|enq_alloc);
         end

         for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            p = int'(r_pending[c]) + int'(enq_pend[c]) - int'(grant[c]) - int'(deq_pend[c]);
            if (p < 0) begin
               w_err_nxt        = 1'b1;
               w_pending_nxt[c] = '0;
            end else begin
               w_pending_nxt[c] = PEND_W'(p);
            end
         end
      end

      for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
         if (grant[c] || enq_alloc[c]) begin
            if (!bus.credit_release[c])
               w_credit_nxt[c] = r_credit[c] - CREDIT_W'(1);
         end else if (bus.credit_release[c]) begin
            if (r_credit[c] == CREDIT_W'(CREDIT_MAX))
               w_err_nxt = 1'b1;
            else
               w_credit_nxt[c] = r_credit[c] + CREDIT_W'(1);
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= '0;
         r_is_read <= '0;
         r_allow   <= '0;
         r_err     <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            r_ch[i] <= '0;
         for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            r_credit[c]  <= CREDIT_W'(CREDIT_MAX);
            r_pending[c] <= '0;
         end
      end else begin
         r_valid   <= w_valid_nxt;
         r_is_read <= w_is_read_nxt;
         r_allow   <= w_allow_nxt;
         r_err     <= w_err_nxt;
         r_ch      <= w_ch_nxt;
         r_credit  <= w_credit_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   assign bus.credit_allow = r_allow;
   assign bus.err          = r_err;

   for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_out
      assign bus.credit_num[g*CREDIT_W +: CREDIT_W] = r_credit[g];
      assign bus.pending_num[g*PEND_W +: PEND_W]    = r_pending[g];
   end
endmodule

// File: tb/tb_bank_isu_credit_ctrl.sv
// Bench for bank_isu_credit_ctrl: vector table, directed corner sequences and
// randomized legal traffic checked against an entry-level behavioural model.
module tb_bank_isu_credit_ctrl;
   localparam int CH   = 4;
   localparam int DP   = 16;
   localparam int CMAX = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   bank_isu_credit_ctrl_if #(.CHANNEL_NUM(4), .CH_ID_W(2), .PTR_WIDTH(4), .DEPTH(16), .CREDIT_W(4)) bus ();

   bank_isu_credit_ctrl #(
      .CHANNEL_NUM(4), .CH_ID_W(2), .PTR_WIDTH(4), .DEPTH(16), .CREDIT_MAX(8), .CREDIT_W(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        enq_v;
      logic [3:0]  enq_p;
      logic        rd;
      logic [1:0]  ch;
      logic        deq_v;
      logic [3:0]  deq_p;
      logic [3:0]  rel;
      logic [15:0] allow;
      logic [15:0] cred;
      logic [19:0] pend;
      logic        err;
   } vec_t;

   vec_t tbl[12];

   // Behavioural model: one record per IQ slot; waiting reads are counted, not tracked
   bit m_valid[DP];
   bit m_read[DP];
   bit m_allow[DP];
   int m_ch[DP];
   int m_credit[CH];
   bit m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_all(input string name, input logic [15:0] allow, input logic [15:0] cred,
                            input logic [19:0] pend, input logic err);
      check({name, ".allow"},   32'(bus.credit_allow), 32'(allow));
      check({name, ".credit"},  32'(bus.credit_num),   32'(cred));
      check({name, ".pending"}, 32'(bus.pending_num),  32'(pend));
      check({name, ".err"},     32'(bus.err),          32'(err));
   endtask

   task automatic set_idle();
      bus.enq_valid = 1'b0; bus.enq_ptr = '0; bus.enq_is_read = 1'b0; bus.enq_ch_id = '0;
      bus.deq_valid = 1'b0; bus.deq_ptr = '0; bus.flush = 1'b0; bus.bottom_ptr = '0;
      bus.credit_release = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ev, input logic [3:0] ep, input logic rd, input logic [1:0] ch,
                        input logic dv, input logic [3:0] dp, input logic fl,
                        input logic [3:0] bot, input logic [3:0] rel);
      bus.enq_valid = ev; bus.enq_ptr = ep; bus.enq_is_read = rd; bus.enq_ch_id = ch;
      bus.deq_valid = dv; bus.deq_ptr = dp; bus.flush = fl; bus.bottom_ptr = bot;
      bus.credit_release = rel;
      tick();
      set_idle();
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      #3;
      tick();
      rst = 1'b0;
   endtask

   function automatic void model_reset();
      for (int s = 0; s < DP; s++) begin
         m_valid[s] = 0; m_read[s] = 0; m_allow[s] = 0; m_ch[s] = 0;
      end
      for (int c = 0; c < CH; c++) m_credit[c] = CMAX;
      m_err = 0;
   endfunction

   function automatic int waiting(input int c);
      int n = 0;
      for (int s = 0; s < DP; s++)
         if (m_valid[s] && m_read[s] && !m_allow[s] && m_ch[s] == c) n++;
      return n;
   endfunction

   // Advance the model by one clock using the inputs currently on the bus
   function automatic void model_step();
      int gslot[CH];
      bit alloc[CH];
      int pend[CH];
      int best;
      int d;
      int ech;
      ech = int'(bus.enq_ch_id);
      for (int c = 0; c < CH; c++) begin
         gslot[c] = -1; alloc[c] = 0; pend[c] = waiting(c);
      end
      if (!bus.flush) begin
         for (int c = 0; c < CH; c++) begin
            best = DP;
            if (m_credit[c] > 0)
               for (int s = 0; s < DP; s++)
                  if (m_valid[s] && m_read[s] && !m_allow[s] && m_ch[s] == c) begin
                     d = (s - int'(bus.bottom_ptr) + DP) % DP;
                     if (d < best) begin best = d; gslot[c] = s; end
                  end
         end
         if (bus.enq_valid && bus.enq_is_read && pend[ech] == 0 && m_credit[ech] > 0 && gslot[ech] < 0)
            alloc[ech] = 1;
      end
      for (int c = 0; c < CH; c++) begin
         if ((gslot[c] >= 0 || alloc[c]) && !bus.credit_release[c]) m_credit[c]--;
         else if (!(gslot[c] >= 0 || alloc[c]) && bus.credit_release[c]) begin
            if (m_credit[c] == CMAX) m_err = 1;
            else m_credit[c]++;
         end
      end
      if (bus.flush) begin
         for (int s = 0; s < DP; s++) begin m_valid[s] = 0; m_allow[s] = 0; end
      end else begin
         for (int c = 0; c < CH; c++) if (gslot[c] >= 0) m_allow[gslot[c]] = 1;
         if (bus.deq_valid) begin
            m_valid[bus.deq_ptr] = 0; m_allow[bus.deq_ptr] = 0;
         end
         if (bus.enq_valid) begin
            m_valid[bus.enq_ptr] = 1;
            m_read[bus.enq_ptr]  = bus.enq_is_read;
            m_ch[bus.enq_ptr]    = ech;
            m_allow[bus.enq_ptr] = !bus.enq_is_read || alloc[ech];
         end
      end
   endfunction

   task automatic model_compare();
      logic [15:0] a;
      logic [15:0] cr;
      logic [19:0] pn;
      for (int s = 0; s < DP; s++) a[s] = m_allow[s];
      for (int c = 0; c < CH; c++) begin
         cr[c*4 +: 4] = 4'(m_credit[c]);
         pn[c*5 +: 5] = 5'(waiting(c));
      end
      check_all("rand", a, cr, pn, m_err);
   endtask

   initial begin
      logic       dv, ev, found;
      logic [3:0] dp, ep;
      int         st;

      set_idle();
      #3;
      tick();
      rst = 1'b0;
      check_all("reset", 16'h0000, 16'h8888, 20'h0, 1'b0);

      // Table: read ch1 slot0, then reuse slot0 for ch0 and fill ch0 past its credits
      tbl[0] = '{1'b1, 4'd0, 1'b1, 2'd1, 1'b0, 4'd0, 4'h0, 16'h0001, 16'h8878, 20'h0, 1'b0};
      tbl[1] = '{1'b1, 4'd0, 1'b1, 2'd0, 1'b1, 4'd0, 4'h0, 16'h0001, 16'h8877, 20'h0, 1'b0};
      for (int i = 1; i <= 7; i++)
         tbl[i+1] = '{1'b1, 4'(i), 1'b1, 2'd0, 1'b0, 4'd0, 4'h0,
                      16'((1 << (i + 1)) - 1), 16'h8870 | 16'(7 - i), 20'h0, 1'b0};
      tbl[9]  = '{1'b1, 4'd8, 1'b1, 2'd0, 1'b0, 4'd0, 4'h0, 16'h00FF, 16'h8870, 20'h1, 1'b0};
      tbl[10] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'h1, 16'h00FF, 16'h8871, 20'h1, 1'b0};
      tbl[11] = '{1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'h0, 16'h01FF, 16'h8870, 20'h0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].enq_v, tbl[i].enq_p, tbl[i].rd, tbl[i].ch, tbl[i].deq_v, tbl[i].deq_p,
               1'b0, 4'd0, tbl[i].rel);
         check_all($sformatf("vec%0d", i), tbl[i].allow, tbl[i].cred, tbl[i].pend, tbl[i].err);
      end

      // Age wraps around the queue end: slot15 is older than slot3 when bottom is 14
      do_reset();
      for (int i = 4; i <= 11; i++) drive(1'b1, 4'(i), 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      drive(1'b1, 4'd3, 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      drive(1'b1, 4'd15, 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      check_all("wrap.setup", 16'h8FF0 & 16'h0FF0, 16'h8088, 20'h00800, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd14, 4'h4);
      check_all("wrap.rel", 16'h0FF0, 16'h8188, 20'h00800, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd14, 4'h0);
      check_all("wrap.grant", 16'h8FF0, 16'h8088, 20'h00400, 1'b0);

      // Grant and new read on the same channel: the new read must wait
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd14, 4'h4);
      drive(1'b1, 4'd12, 1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 4'd14, 4'h0);
      check_all("fair", 16'h8FF8, 16'h8088, 20'h00400, 1'b0);

      // Simultaneous alloc and release, then release at full credit
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 4'(i), 1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      check_all("ch3.four", 16'h000F, 16'h4888, 20'h0, 1'b0);
      drive(1'b1, 4'd4, 1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'h8);
      check_all("ch3.same", 16'h001F, 16'h4888, 20'h0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h8);
      check_all("ch3.full", 16'h001F, 16'h8888, 20'h0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h8);
      check_all("ch3.over", 16'h001F, 16'h8888, 20'h0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      check("ch3.sticky", 32'(bus.err), 32'd1);

      // Flush with waiting reads; release during flush still counts
      do_reset();
      for (int i = 0; i <= 10; i++) drive(1'b1, 4'(i), 1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      check_all("flush.pre", 16'h00FF, 16'h8880, 20'h3, 1'b0);
      drive(1'b1, 4'd11, 1'b1, 2'd1, 1'b0, 4'd0, 1'b1, 4'd0, 4'h1);
      check_all("flush", 16'h0000, 16'h8881, 20'h0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h1);
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'h1);
      check_all("flush.rel", 16'h0000, 16'h8883, 20'h0, 1'b0);

      // Asynchronous reset mid-traffic, observed before any clock edge
      drive(1'b1, 4'd0, 1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'h0);
      bus.enq_valid = 1'b1; bus.enq_ptr = 4'd1; bus.enq_is_read = 1'b1; bus.enq_ch_id = 2'd2;
      #3;
      rst = 1'b1;
      #1;
      check_all("async_rst", 16'h0000, 16'h8888, 20'h0, 1'b0);
      set_idle();
      tick();
      rst = 1'b0;

      // Dequeue of an empty slot
      drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'h0);
      check_all("deq_empty", 16'h0000, 16'h8888, 20'h0, 1'b1);

      // Randomized legal traffic against the model
      do_reset();
      model_reset();
      for (int n = 0; n < 1500; n++) begin
         set_idle();
         bus.bottom_ptr = 4'($urandom_range(0, 15));
         bus.flush      = ($urandom_range(0, 59) == 0);
         dv = 1'b0; dp = '0; ev = 1'b0; ep = '0;
         if ($urandom_range(0, 1) == 1) begin
            st = $urandom_range(0, 15);
            found = 1'b0;
            for (int k = 0; k < DP; k++)
               if (!found && m_valid[(st + k) % DP] && m_allow[(st + k) % DP]) begin
                  found = 1'b1; dv = 1'b1; dp = 4'((st + k) % DP);
               end
         end
         if ($urandom_range(0, 2) != 0) begin
            st = $urandom_range(0, 15);
            found = 1'b0;
            for (int k = 0; k < DP; k++)
               if (!found && (!m_valid[(st + k) % DP] || (dv && dp == 4'((st + k) % DP)))) begin
                  found = 1'b1; ev = 1'b1; ep = 4'((st + k) % DP);
               end
         end
         bus.deq_valid   = dv;
         bus.deq_ptr     = dp;
         bus.enq_valid   = ev;
         bus.enq_ptr     = ep;
         bus.enq_is_read = ($urandom_range(0, 3) != 0);
         bus.enq_ch_id   = 2'($urandom_range(0, 3));
         for (int c = 0; c < CH; c++)
            bus.credit_release[c] = (m_credit[c] < CMAX) && ($urandom_range(0, 2) == 0);
         model_step();
         tick();
         model_compare();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
